// File: rtl/router_pkg.sv
// Shared packet field layout for the spiking-NoC router path.
// The arbiter-side packetizer and every downstream consumer decode packets
// from these constants so the field positions cannot drift apart.
package router_pkg;

    localparam int PKT_W       = 32;
    localparam int DEST_W_DEF  = 2;                       // 4 destination ports
    localparam int DEST_MSB    = PKT_W - 1;
    localparam int DEST_LSB    = DEST_MSB - DEST_W_DEF + 1;
    localparam int SRC_W       = 4;                       // originating arbiter input / PE id
    localparam int SRC_MSB     = DEST_LSB - 1;
    localparam int SRC_LSB     = SRC_MSB - SRC_W + 1;
    localparam int PAYLOAD_W   = SRC_LSB;
    localparam int PAYLOAD_MSB = PAYLOAD_W - 1;
    localparam int CNT_W       = 16;                      // delivered-packet counter width

    typedef logic [PKT_W-1:0] pkt_t;

    // Destination field of a packet using the default field width.
    function automatic logic [DEST_W_DEF-1:0] pkt_dest(input pkt_t p);
        return p[DEST_MSB -: DEST_W_DEF];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: storage, wrap-around pointers and an explicit
// occupancy counter (no full/empty ambiguity). Pushes while full and pops
// while empty are ignored. Read data is the current head, combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/packet_demux_router.sv
// Output stage behind the arbiter tree: buffers the arbitrated packet stream,
// holds the head packet in an output register with its destination pre-decoded
// to one-hot, and hands it to exactly one consumer port. Strict in-order: a
// blocked head stalls everything behind it and back-pressures the arbiter.
module packet_demux_router
    import router_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 4,
    parameter int DEPTH   = 4,
    parameter int DEST_W  = $clog2(NUM_OUT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [NUM_OUT*CNT_W-1:0]   deliv_cnt
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_head;
    logic                 push;
    logic                 load;
    logic                 deliver;
    logic [NUM_OUT-1:0]   head_oh;

    // Output register: one-hot destination doubles as the valid bit (zero = empty).
    logic [NUM_OUT-1:0]   or_oh;
    logic [WIDTH-1:0]     or_data;
    logic [CNT_W-1:0]     cnt_q [NUM_OUT];

    // in_ready only looks at registered occupancy, so no in->out combinational path.
    assign in_ready  = rst_n && !fifo_full;
    assign push      = in_valid && in_ready;

    assign head_oh   = NUM_OUT'(1) << fifo_head[WIDTH-1 -: DEST_W];
    assign deliver   = |(or_oh & out_ready);
    assign load      = !fifo_empty && ((or_oh == '0) || deliver);

    assign out_valid = or_oh;
    assign out_data  = or_data;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (load),
        .wdata (in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Output register: refill from the FIFO head on load, otherwise empty on delivery.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_oh   <= '0;
            or_data <= '0;
        end else if (load) begin
            or_oh   <= head_oh;
            or_data <= fifo_head;
        end else if (deliver) begin
            or_oh   <= '0;
        end
    end

    // Per-port delivered counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_OUT; d++) begin
            if (!rst_n)
                cnt_q[d] <= '0;
            else if (or_oh[d] && out_ready[d] && (cnt_q[d] != '1))
                cnt_q[d] <= cnt_q[d] + CNT_W'(1);
        end
    end

    for (genvar d = 0; d < NUM_OUT; d++) begin : g_cnt_out
        assign deliv_cnt[d*CNT_W +: CNT_W] = cnt_q[d];
    end

endmodule

// File: tb/tb_packet_demux_router.sv
// Scoreboard bench for packet_demux_router: stimulus pushes accepted packets
// into an in-order queue; a negedge monitor checks every presented packet
// against the queue head and keeps reference delivery counts.
module tb_packet_demux_router;

    localparam int WIDTH   = 32;
    localparam int NUM_OUT = 4;
    localparam int DEPTH   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [2:0]               level;
    logic [NUM_OUT*16-1:0]    deliv_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] sb [$];
    int               mcnt [NUM_OUT];
    logic             rst_edge = 1'b0;

    packet_demux_router #(
        .WIDTH   (WIDTH),
        .NUM_OUT (NUM_OUT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .deliv_cnt (deliv_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int dest_of(input logic [WIDTH-1:0] p);
        return int'(p[WIDTH-1:WIDTH-2]);
    endfunction

    // Remembers whether the most recent clock edge saw reset asserted.
    always @(posedge clk) rst_edge <= !rst_n;

    // Monitor: outputs are stable here; handshakes seen now complete at the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            for (int d = 0; d < NUM_OUT; d++) mcnt[d] = 0;
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            if (rst_edge) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_data",  64'(out_data),  64'd0);
                chk("rst_level",     64'(level),     64'd0);
                chk("rst_deliv_cnt", 64'(deliv_cnt), 64'd0);
            end
        end else begin
            chk("occupancy", 64'(int'(level) + ((out_valid != 0) ? 1 : 0)), 64'(sb.size()));
            chk("in_ready_rule", 64'(in_ready), 64'(int'(level) != DEPTH));
            if (out_valid != 0) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    logic [WIDTH-1:0] exp;
                    int dd;
                    exp = sb[0];
                    dd  = dest_of(exp);
                    chk("out_valid_port", 64'(out_valid), 64'(1 << dd));
                    chk("out_data_order", 64'(out_data), 64'(exp));
                    if ((out_valid & out_ready) != 0) begin
                        void'(sb.pop_front());
                        if (mcnt[dd] < 16'hFFFF) mcnt[dd]++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = '1;
        while ((sb.size() != 0 || out_valid != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n >= 200), 64'd0);
        repeat (2) tick();
    endtask

    task automatic cmp_cnts(input string name);
        for (int d = 0; d < NUM_OUT; d++)
            chk(name, 64'(deliv_cnt[d*16 +: 16]), 64'(mcnt[d]));
    endtask

    initial begin
        logic [WIDTH-1:0] p2;
        logic [15:0]      c0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        tick();

        // Single packet latency: accepted at edge k, visible after edge k+1.
        in_valid = 1'b1;
        in_data  = 32'h4000_00AA;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_early", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid), 64'b0010);
        chk("latency_out_data",  64'(out_data),  64'h4000_00AA);
        repeat (2) tick();
        @(negedge clk);
        chk("single_cnt1",  64'(deliv_cnt[31:16]), 64'd1);
        chk("single_level", 64'(level), 64'd0);
        tick();

        // Burst of 8, dests 0..3 twice, all ready: in_ready must never drop.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = {2'(i % 4), 30'($urandom)};
            @(negedge clk);
            chk("burst_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        drain();
        cmp_cnts("burst_cnt");
        chk("burst_cnt0", 64'(deliv_cnt[15:0]),  64'd2);
        chk("burst_cnt3", 64'(deliv_cnt[63:48]), 64'd2);

        // Port 2 stalled: dest 2 at the head blocks four dest-0 packets behind it.
        out_ready = 4'b1011;
        c0 = deliv_cnt[15:0];
        p2 = {2'd2, 30'($urandom)};
        in_valid = 1'b1;
        in_data  = p2;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = {2'd0, 30'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'b0100);
            chk("stall_out_data",  64'(out_data),  64'(p2));
            chk("stall_level",     64'(level),     64'd4);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_no_port0",  64'(deliv_cnt[15:0]), 64'(c0));
            tick();
        end

        // Full FIFO with a pop in the same cycle: no push until the next cycle.
        in_valid  = 1'b1;
        in_data   = {2'd0, 30'($urandom)};
        out_ready = '1;
        @(negedge clk);
        chk("full_pop_in_ready", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("full_pop_level",    64'(level),    64'd3);
        chk("full_pop_ready_nx", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        drain();
        cmp_cnts("stall_cnt");

        // Randomized traffic with random consumer back-pressure.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
            tick();
        end
        drain();
        cmp_cnts("random_cnt");

        // Mid-operation reset with level 3 and the output register occupied.
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_level", 64'(level), 64'd3);
        chk("pre_rst_or",    64'(out_valid != 0), 64'd1);
        tick();
        out_ready = '1;
        rst_n     = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_level",     64'(level),     64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
        chk("mid_rst_cnt",       64'(deliv_cnt), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Saturation of port 3's counter: 65537 dest-3 packets at full rate.
        out_ready = '1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = {2'd3, 30'($urandom)};
            tick();
        end
        drain();
        cmp_cnts("sat_cnt");
        chk("sat_cnt3", 64'(deliv_cnt[63:48]), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
